pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; drives the enables and bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards between the instruction in ID and the instruction in EX.
- Freezes the front end while a multi-cycle ALU op occupies EX.
- Flushes wrong-path instructions on a taken branch, and keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 6, register-specifier width (matches the rs/rt/rd fields).
- MULTI_CYCLES, 4, total EX occupancy of a multi-cycle op; legal range 2..255.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- idRs  in  REG_W  source register rs of the instruction in ID.
- idRt  in  REG_W  source register rt of the instruction in ID.
- idUsesRs  in  1  ID instruction reads rs.
- idUsesRt  in  1  ID instruction reads rt.
- idMulti  in  1  ID instruction is a multi-cycle ALU op.
- exRd  in  REG_W  destination register of the instruction in EX (ID/EX output).
- exMemRead  in  1  EX instruction is a load.
- branchTaken  in  1  taken branch/jump resolved this cycle; redirect is applied by the PC mux.
- statClr  in  1  synchronous clear of stallCnt.
- pcWrite  out  1  PC load enable.
- ifIdWrite  out  1  IF/ID load enable.
- ifIdFlush  out  1  zero the IF/ID instruction field.
- idExBubble  out  1  load zero wb/mem/ex control fields into ID/EX.
- idExHold  out  1  hold ID/EX contents.
- exMemBubble  out  1  load zero control fields into EX/MEM.
- busy  out  1  multi-cycle op in progress.
- stallCnt  out  CNT_W  count of cycles with pcWrite=0.

Behaviour:
- State registers: state ∈ {RUN, BUSY}, down-counter cnt[7:0], stallCnt.
- Control outputs are combinational from state and the current inputs (Mealy), giving zero-cycle response to hazards.
- Defaults, unless a rule below overrides them: pcWrite=1, ifIdWrite=1, all other control outputs 0.
- loadUse = exMemRead & (exRd≠0) & ((idUsesRs & idRs==exRd) | (idUsesRt & idRt==exRd)). Register 0 never causes a hazard.
- RUN state, priority order:
  1. branchTaken=1: ifIdFlush=1, idExBubble=1, pcWrite=1, ifIdWrite=1. Stay in RUN. idMulti and loadUse are ignored (wrong path).
  2. loadUse=1: pcWrite=0, ifIdWrite=0, idExBubble=1. Stay in RUN. Exactly one bubble per load-use pair; the next cycle re-evaluates.
  3. idMulti=1: default outputs. Next state BUSY, cnt←MULTI_CYCLES-1.
  4. Otherwise: default outputs. Stay in RUN.
- BUSY state:
  - branchTaken=1: abort. Same outputs as RUN rule 1, idExHold=0. Next state RUN, cnt←0.
  - Otherwise: pcWrite=0, ifIdWrite=0, idExHold=1, exMemBubble=1, busy=1. loadUse and idMulti are ignored.
  - Exit: if cnt==1, next state RUN, cnt←0; else cnt←cnt-1. BUSY therefore lasts exactly MULTI_CYCLES-1 cycles.
  - Back-to-back: an idMulti seen on the first RUN cycle after BUSY starts a new BUSY normally.
- stallCnt:
  - Increments by 1 on each clock where pcWrite=0 and rst=0.
  - Saturates at all-ones; no wrap.
  - statClr=1 forces 0 on that edge and overrides the increment.
- Reset (rst=1 at a clock edge): state←RUN, cnt←0, stallCnt←0.
  - While rst is high, all control outputs are forced to 0 (including pcWrite and ifIdWrite), and busy=0.
  - Reset taken mid-BUSY aborts the op with no residual stall.

Test Plan:
- Load-use: exMemRead=1, exRd=5, idRs=5, idUsesRs=1 for one cycle, then exMemRead=0 -> that cycle pcWrite=0, ifIdWrite=0, idExBubble=1; next cycle defaults; stallCnt=1. Repeat with exRd=0 -> no stall.
- rt path and unused operand: idRt=5, idUsesRt=1 -> stall; idUsesRt=0 with the same fields -> no stall.
- Multi-cycle op: idMulti=1 in RUN, MULTI_CYCLES=4 -> next 3 cycles busy=1, idExHold=1, exMemBubble=1, pcWrite=0; 4th cycle RUN with defaults; stallCnt +3.
- Branch abort in BUSY: branchTaken=1 on the 2nd BUSY cycle -> that cycle ifIdFlush=1, idExBubble=1, pcWrite=1; next cycle RUN, busy=0.
- Priority and reset: branchTaken=1 together with loadUse=1 and idMulti=1 -> flush only, state stays RUN. rst=1 mid-BUSY -> next cycle RUN, stallCnt=0; outputs 0 while rst is high.
- Counter saturation and clear: CNT_W=4, hold loadUse for 20 cycles -> stallCnt sticks at 15; statClr=1 during a stall -> 0 after the edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards (one bubble per pair), freezes the front end
// while a multi-cycle ALU op occupies EX, flushes the wrong path on a taken
// branch, and counts stall cycles in a saturating counter.
// There is no valid/ready handshake in this block: every control output is a
// per-cycle level, valid in the same cycle as the inputs that produce it.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 6,
  parameter int MULTI_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] idRs,
  input  logic [REG_W-1:0] idRt,
  input  logic             idUsesRs,
  input  logic             idUsesRt,
  input  logic             idMulti,
  input  logic [REG_W-1:0] exRd,
  input  logic             exMemRead,
  input  logic             branchTaken,
  input  logic             statClr,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExBubble,
  output logic             idExHold,
  output logic             exMemBubble,
  output logic             busy,
  output logic [CNT_W-1:0] stallCnt,
  output logic             dbgState,
  output logic [7:0]       dbgCnt
);

  typedef enum logic {RUN = 1'b0, BUSY = 1'b1} state_t;

  // Loading MULTI_CYCLES-1 and leaving on cnt==1 gives MULTI_CYCLES-1 frozen
  // cycles; the cycle that issued the op into EX is the first occupancy cycle.
  localparam logic [7:0] CNT_LOAD = 8'(MULTI_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       load_use;

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = exMemRead && (exRd != '0) &&
                    ((idUsesRs && (idRs == exRd)) || (idUsesRt && (idRt == exRd)));

  assign dbgState = (state == BUSY);
  assign dbgCnt   = cnt;

  // Next-state and Mealy control outputs; defaults let the pipeline advance.
  always_comb begin
    pcWrite     = 1'b1;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    idExHold    = 1'b0;
    exMemBubble = 1'b0;
    busy        = 1'b0;
    state_nxt   = state;
    cnt_nxt     = cnt;
    if (rst) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      case (state)
        RUN: begin
          if (branchTaken) begin
            // Wrong-path instructions in IF/ID and ID are squashed.
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
          end else if (load_use) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExBubble = 1'b1;
          end else if (idMulti) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end
        end
        BUSY: begin
          if (branchTaken) begin
            ifIdFlush  = 1'b1;
            idExBubble = 1'b1;
            state_nxt  = RUN;
            cnt_nxt    = '0;
          end else begin
            pcWrite     = 1'b0;
            ifIdWrite   = 1'b0;
            idExHold    = 1'b1;
            exMemBubble = 1'b1;
            busy        = 1'b1;
            if (cnt == 8'd1) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end else begin
              cnt_nxt = cnt - 8'd1;
            end
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and occupancy counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || statClr) begin
      stallCnt <= '0;
    end else if (!pcWrite && (stallCnt != CNT_MAX)) begin
      stallCnt <= stallCnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios plus randomized traffic, all
// checked against a cycle-level reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 6;
  localparam int MULTI = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Control vector order: {pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExHold, exMemBubble, busy}
  localparam logic [6:0] C_NORMAL = 7'b1100000;
  localparam logic [6:0] C_FLUSH  = 7'b1111000;
  localparam logic [6:0] C_STALL  = 7'b0001000;
  localparam logic [6:0] C_FREEZE = 7'b0000111;
  localparam logic [6:0] C_RESET  = 7'b0000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [REG_W-1:0] idRs, idRt, exRd;
  logic             idUsesRs, idUsesRt, idMulti, exMemRead, branchTaken, statClr;
  logic             pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExHold, exMemBubble, busy;
  logic [CNT_W-1:0] stallCnt;
  logic             dbgState;
  logic [7:0]       dbgCnt;
  logic [6:0]       obs_ctl;

  assign obs_ctl = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, idExHold, exMemBubble, busy};

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MULTI_CYCLES(MULTI), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs),
    .idUsesRt(idUsesRt), .idMulti(idMulti), .exRd(exRd), .exMemRead(exMemRead),
    .branchTaken(branchTaken), .statClr(statClr), .pcWrite(pcWrite),
    .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush), .idExBubble(idExBubble),
    .idExHold(idExHold), .exMemBubble(exMemBubble), .busy(busy),
    .stallCnt(stallCnt), .dbgState(dbgState), .dbgCnt(dbgCnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  // m_frozen: remaining frozen cycles of the current multi-cycle op.
  int         m_frozen   = 0;
  int         m_frozen_n = 0;
  int         m_stall    = 0;
  logic [6:0] exp_ctl;
  logic [CNT_W-1:0] exp_cnt;

  task automatic model_eval();
    logic hazard;
    hazard = exMemRead && (exRd != 0) &&
             ((idUsesRs && idRs == exRd) || (idUsesRt && idRt == exRd));
    m_frozen_n = m_frozen;
    if (rst) begin
      exp_ctl = C_RESET; m_frozen_n = 0;
    end else if (branchTaken) begin
      exp_ctl = C_FLUSH; m_frozen_n = 0;
    end else if (m_frozen > 0) begin
      exp_ctl = C_FREEZE; m_frozen_n = m_frozen - 1;
    end else if (hazard) begin
      exp_ctl = C_STALL;
    end else if (idMulti) begin
      exp_ctl = C_NORMAL; m_frozen_n = MULTI - 1;
    end else begin
      exp_ctl = C_NORMAL;
    end
    exp_cnt = CNT_W'(m_stall);
  endtask

  task automatic model_commit();
    m_frozen = m_frozen_n;
    if (rst || statClr) m_stall = 0;
    else if (!exp_ctl[6] && m_stall < CMAX) m_stall++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rst = 1'b0; idRs = '0; idRt = '0; exRd = '0;
    idUsesRs = 1'b0; idUsesRt = 1'b0; idMulti = 1'b0;
    exMemRead = 1'b0; branchTaken = 1'b0; statClr = 1'b0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic cycle_start();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic set_load(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs,
                          input logic urs, input logic [REG_W-1:0] rt, input logic urt);
    exMemRead = 1'b1; exRd = rd; idRs = rs; idUsesRs = urs; idRt = rt; idUsesRt = urt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cycle_start();
      rst = 1'b1; idMulti = 1'($urandom_range(0, 1)); branchTaken = 1'($urandom_range(0, 1));
      set_load(6'd3, 6'd3, 1'b1, 6'd0, 1'b0);
      settle();
      n_total++;
      if (obs_ctl !== C_RESET || busy !== 1'b0) begin
        $display("FAIL reset_outputs cyc%0d got ctl=%b want ctl=%b", i, obs_ctl, C_RESET);
      end else n_pass++;
      model_commit();
    end
    cycle_start();
    settle();
    n_total++;
    if (stallCnt !== '0 || obs_ctl !== C_NORMAL) begin
      $display("FAIL reset_state got ctl=%b cnt=%0d want ctl=%b cnt=0", obs_ctl, stallCnt, C_NORMAL);
    end else n_pass++;
    model_commit();
  endtask

  task automatic test_load_use();
    // rs hit, then idle, then the same pair against r0 (no hazard), then idle
    for (int i = 0; i < 4; i++) begin
      cycle_start();
      if (i == 0) set_load(6'd5, 6'd5, 1'b1, 6'd9, 1'b0);
      if (i == 2) set_load(6'd0, 6'd0, 1'b1, 6'd0, 1'b1);
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL load_use step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_rt_path();
    // rt hit, idle, then the same fields with rt unused, idle
    for (int i = 0; i < 4; i++) begin
      cycle_start();
      if (i == 0) set_load(6'd5, 6'd1, 1'b0, 6'd5, 1'b1);
      if (i == 2) set_load(6'd5, 6'd1, 1'b0, 6'd5, 1'b0);
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL rt_path step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_multi_cycle();
    // issue, MULTI-1 frozen cycles (hazard inputs must be ignored), then RUN
    for (int i = 0; i < MULTI + 1; i++) begin
      cycle_start();
      if (i == 0) idMulti = 1'b1;
      if (i == 2) set_load(6'd7, 6'd7, 1'b1, 6'd0, 1'b0);
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL multi_cycle step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_branch_abort();
    for (int i = 0; i < 4; i++) begin
      cycle_start();
      if (i == 0) idMulti = 1'b1;
      if (i == 2) branchTaken = 1'b1;
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL branch_abort step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 2; i++) begin
      cycle_start();
      if (i == 0) begin
        branchTaken = 1'b1; idMulti = 1'b1;
        set_load(6'd4, 6'd4, 1'b1, 6'd4, 1'b1);
      end
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL priority step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int i = 0; i < 4; i++) begin
      cycle_start();
      if (i == 0) idMulti = 1'b1;
      if (i == 2) rst = 1'b1;
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL reset_mid_busy step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_back_to_back();
    // second op issued on the first RUN cycle after the first op
    for (int i = 0; i < 2 * MULTI + 1; i++) begin
      cycle_start();
      if (i == 0 || i == MULTI) idMulti = 1'b1;
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL back_to_back step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 23; i++) begin
      cycle_start();
      if (i == 0) statClr = 1'b1;
      if (i >= 1 && i <= 21) set_load(6'd2, 6'd2, 1'b1, 6'd0, 1'b0);
      if (i == 21) statClr = 1'b1;
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL saturation step%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      if (i == 21) begin
        n_total++;
        if (stallCnt !== 4'd15) $display("FAIL saturation_hold got cnt=%0d want cnt=15", stallCnt);
        else n_pass++;
      end
      if (i == 22) begin
        n_total++;
        if (stallCnt !== 4'd0) $display("FAIL stat_clear got cnt=%0d want cnt=0", stallCnt);
        else n_pass++;
      end
      model_commit();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cycle_start();
      rst         = ($urandom_range(0, 40) == 0);
      statClr     = ($urandom_range(0, 15) == 0);
      branchTaken = ($urandom_range(0, 7) == 0);
      idMulti     = ($urandom_range(0, 5) == 0);
      exMemRead   = 1'($urandom_range(0, 1));
      exRd        = REG_W'($urandom_range(0, 3));
      idRs        = REG_W'($urandom_range(0, 3));
      idRt        = REG_W'($urandom_range(0, 3));
      idUsesRs    = 1'($urandom_range(0, 1));
      idUsesRt    = 1'($urandom_range(0, 1));
      settle();
      n_total++;
      if ({obs_ctl, stallCnt} !== {exp_ctl, exp_cnt}) begin
        $display("FAIL random cyc%0d got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, obs_ctl, stallCnt, exp_ctl, exp_cnt);
      end else n_pass++;
      model_commit();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_rt_path();
    test_multi_cycle();
    test_branch_abort();
    test_priority();
    test_reset_mid_busy();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
